neo_mc_detector: RTL and testbench

Multi-channel, parametrised-lag Nonlinear Energy Operator with built-in spike detection.
- Accepts a time-multiplexed stream of signed samples tagged with a channel index.
- Computes psi[n] = x[n-K]^2 - x[n]*x[n-2K] per channel, where K is the lag.
- Compares psi against a runtime threshold and applies a per-channel refractory hold-off.
- Sits between the ADC sample interface and the spike-sorting / event logger. It is the multi-channel, k-lag successor to the single-channel NEO.

---
 rtl/neo_mc_detector.sv | 167 ++++++++++++++++
 tb/tb_neo_mc_detector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_mc_detector.sv
// Multi-channel, parametrised-lag Nonlinear Energy Operator with spike detection.
// Each channel keeps a 2K-deep sample history and computes
// psi[n] = x[n-K]^2 - x[n]*x[n-2K]. The result is saturated to M bits and
// compared against a runtime threshold. A per-channel refractory hold-off,
// counted in that channel's outputs, suppresses repeat detections.
module neo_mc_detector #(
  parameter int N  = 16,
  parameter int M  = 32,
  parameter int CH = 4,
  parameter int K  = 1,
  parameter int RW = 8,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [CHW-1:0]        in_ch,
  input  logic signed [N-1:0]   in_data,
  input  logic signed [M-1:0]   threshold,
  input  logic [RW-1:0]         refract_len,
  output logic                  out_valid,
  output logic [CHW-1:0]        out_ch,
  output logic signed [M-1:0]   out_energy,
  output logic                  out_sat,
  output logic                  spike
);

  localparam int D  = 2 * K;
  localparam int WW = $clog2(D + 1);
  localparam logic [WW-1:0] WARM = WW'(D);
  localparam logic [CHW:0] CH_LIM = (CHW + 1)'(CH);

  logic signed [N-1:0] hist [CH][D];
  logic [WW-1:0]       warm [CH];
  logic [RW-1:0]       refract [CH];

  logic                accept;
  logic                produce;
  logic [CHW-1:0]      ch_idx;
  logic signed [N-1:0] xk;
  logic signed [N-1:0] x2k;

  logic                  s1_valid;
  logic [CHW-1:0]        s1_ch;
  logic signed [2*N-1:0] s1_sq;
  logic signed [2*N-1:0] s1_xp;

  logic signed [2*N:0]   diff;
  logic signed [M-1:0]   sat_e;
  logic                  sat_flag;
  logic                  det;

  // Qualify the incoming sample and pick up the lagged history taps it needs.
  always_comb begin
    accept  = in_valid && ({1'b0, in_ch} < CH_LIM);
    ch_idx  = accept ? in_ch : '0;
    xk      = hist[ch_idx][K-1];
    x2k     = hist[ch_idx][D-1];
    produce = accept && (warm[ch_idx] == WARM);
  end

  // Shift the sample into its channel history and advance its warm-up count.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        warm[c] <= '0;
        for (int i = 0; i < D; i++) begin
          hist[c][i] <= '0;
        end
      end
    end else if (accept) begin
      hist[ch_idx][0] <= in_data;
      for (int i = 1; i < D; i++) begin
        hist[ch_idx][i] <= hist[ch_idx][i-1];
      end
      if (warm[ch_idx] != WARM) begin
        warm[ch_idx] <= warm[ch_idx] + WW'(1);
      end
    end
  end

  // Stage 1: register the two products from the pre-shift history.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_sq    <= '0;
      s1_xp    <= '0;
    end else begin
      s1_valid <= produce;
      if (produce) begin
        s1_ch <= ch_idx;
        s1_sq <= xk * xk;
        s1_xp <= in_data * x2k;
      end
    end
  end

  // Form the full-precision difference one bit wider than the products.
  always_comb begin
    diff = $signed({s1_sq[2*N-1], s1_sq}) - $signed({s1_xp[2*N-1], s1_xp});
  end

  if (M < 2 * N + 1) begin : g_sat
    localparam logic signed [2*N:0] EMAX = {{(2*N+2-M){1'b0}}, {(M-1){1'b1}}};
    localparam logic signed [2*N:0] EMIN = {{(2*N+2-M){1'b1}}, {(M-1){1'b0}}};

    // Clamp the difference to the signed M-bit range and flag any clipping.
    always_comb begin
      sat_e    = diff[M-1:0];
      sat_flag = 1'b0;
      if (diff > EMAX) begin
        sat_e    = {1'b0, {(M-1){1'b1}}};
        sat_flag = 1'b1;
      end else if (diff < EMIN) begin
        sat_e    = {1'b1, {(M-1){1'b0}}};
        sat_flag = 1'b1;
      end
    end
  end else begin : g_nosat
    // The output is wide enough for any difference, so just sign-extend.
    always_comb begin
      sat_e    = M'(diff);
      sat_flag = 1'b0;
    end
  end

  // Strict signed threshold test gated by the channel's refractory count.
  always_comb begin
    det = (sat_e > threshold) && (refract[s1_ch] == '0);
  end

  // Stage 2: register results; energy, channel and flag hold when idle.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_energy <= '0;
      out_sat    <= 1'b0;
      spike      <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      spike     <= s1_valid && det;
      if (s1_valid) begin
        out_ch     <= s1_ch;
        out_energy <= sat_e;
        out_sat    <= sat_flag;
      end
    end
  end

  // Reload the hold-off on a spike, otherwise count it down per output.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        refract[c] <= '0;
      end
    end else if (s1_valid) begin
      if (det) begin
        refract[s1_ch] <= refract_len;
      end else if (refract[s1_ch] != '0) begin
        refract[s1_ch] <= refract[s1_ch] - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_neo_mc_detector.sv
// Testbench for neo_mc_detector: three instances (default, K=2 with CH=3,
// M=24), table-driven stimulus, expected results queued on drive and
// compared when each instance reports out_valid.
module tb_neo_mc_detector;

  typedef struct {
    int     inst;
    int     ch;
    int     data;
    bit     ev;
    longint ee;
    bit     es;
    bit     esp;
  } vec_t;

  typedef struct {
    int     inst;
    int     ch;
    longint e;
    bit     s;
    bit     sp;
    int     cyc;
  } exp_t;

  logic               Clk = 1'b0;
  logic               reset = 1'b1;
  logic [2:0]         ivec = '0;
  logic [1:0]         in_ch = '0;
  logic signed [15:0] in_data = '0;
  logic signed [31:0] thr32 = 32'sh7FFFFFFF;
  logic signed [23:0] thr24 = 24'sh7FFFFF;
  logic [7:0]         rlen = '0;

  logic               ov0, os0, sp0;
  logic [1:0]         och0;
  logic signed [31:0] oe0;
  logic               ov1, os1, sp1;
  logic [1:0]         och1;
  logic signed [31:0] oe1;
  logic               ov2, os2, sp2;
  logic [1:0]         och2;
  logic signed [23:0] oe2;

  vec_t tbl[$];
  exp_t sbq[$];
  int   nTests = 0;
  int   nFail  = 0;
  int   cyc    = 0;

  neo_mc_detector #(.N(16), .M(32), .CH(4), .K(1), .RW(8)) u_dut (
    .Clk(Clk), .reset(reset), .in_valid(ivec[0]), .in_ch(in_ch), .in_data(in_data),
    .threshold(thr32), .refract_len(rlen), .out_valid(ov0), .out_ch(och0),
    .out_energy(oe0), .out_sat(os0), .spike(sp0)
  );

  neo_mc_detector #(.N(16), .M(32), .CH(3), .K(2), .RW(8)) u_k2 (
    .Clk(Clk), .reset(reset), .in_valid(ivec[1]), .in_ch(in_ch), .in_data(in_data),
    .threshold(thr32), .refract_len(rlen), .out_valid(ov1), .out_ch(och1),
    .out_energy(oe1), .out_sat(os1), .spike(sp1)
  );

  neo_mc_detector #(.N(16), .M(24), .CH(4), .K(1), .RW(8)) u_m24 (
    .Clk(Clk), .reset(reset), .in_valid(ivec[2]), .in_ch(in_ch), .in_data(in_data),
    .threshold(thr24), .refract_len(rlen), .out_valid(ov2), .out_ch(och2),
    .out_energy(oe2), .out_sat(os2), .spike(sp2)
  );

  // Free-running clock and edge counter used for latency checks.
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Hard stop in case something never drains.
  initial begin
    #200000;
    $display("[TB] FAIL timeout run did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  function automatic void addVec(int inst, int ch, int data, bit ev = 1'b0,
                                 longint ee = 0, bit es = 1'b0, bit esp = 1'b0);
    vec_t v;
    v.inst = inst; v.ch = ch; v.data = data;
    v.ev = ev; v.ee = ee; v.es = es; v.esp = esp;
    tbl.push_back(v);
  endfunction

  // Drive one sample for one cycle; queue its expected result if it has one.
  task automatic applyStimulus(input int inst, input int ch, input int data, input bit ev,
                               input longint ee, input bit es, input bit esp);
    exp_t x;
    in_ch      = 2'(ch);
    in_data    = 16'(data);
    ivec       = '0;
    ivec[inst] = 1'b1;
    if (ev) begin
      x.inst = inst; x.ch = ch; x.e = ee; x.s = es; x.sp = esp; x.cyc = cyc + 2;
      sbq.push_back(x);
    end
    @(posedge Clk);
    #1;
    ivec = '0;
  endtask

  // Compare one instance's output against the head of the scoreboard.
  task automatic checkOutput(input int inst, input logic v, input logic [1:0] ch,
                             input longint e, input logic s, input logic sp);
    exp_t x;
    if (v) begin
      nTests++;
      if (sbq.size() == 0) begin
        nFail++;
        $display("[TB] FAIL unexpected_out inst=%0d ch=%0d energy=%0d at cycle %0d, required no output",
                 inst, ch, e, cyc);
      end else begin
        x = sbq.pop_front();
        if (x.inst != inst || x.ch != int'(ch) || x.e != e || x.s != s || x.sp != sp || x.cyc != cyc) begin
          nFail++;
          $display("[TB] FAIL out_check got inst=%0d ch=%0d energy=%0d sat=%0b spike=%0b cyc=%0d, required inst=%0d ch=%0d energy=%0d sat=%0b spike=%0b cyc=%0d",
                   inst, ch, e, s, sp, cyc, x.inst, x.ch, x.e, x.s, x.sp, x.cyc);
        end
      end
    end else if (sp) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL spike_idle inst=%0d spike=1 with out_valid=0, required 0", inst);
    end
  endtask

  // Sample all instance outputs on the falling edge.
  always @(negedge Clk) begin
    checkOutput(0, ov0, och0, longint'(oe0), os0, sp0);
    checkOutput(1, ov1, och1, longint'(oe1), os1, sp1);
    checkOutput(2, ov2, och2, longint'(oe2), os2, sp2);
  end

  task automatic checkResetZero(input string tag);
    nTests++;
    if ({ov0, och0, oe0, os0, sp0, ov1, och1, oe1, os1, sp1, ov2, och2, oe2, os2, sp2} != '0) begin
      nFail++;
      $display("[TB] FAIL %s valid=%b%b%b ch=%0d/%0d/%0d energy=%0d/%0d/%0d sat=%b%b%b spike=%b%b%b, required all zero",
               tag, ov0, ov1, ov2, och0, och1, och2, oe0, oe1, oe2, os0, os1, os2, sp0, sp1, sp2);
    end
  endtask

  // Pulse reset away from the rising edge and check outputs clear at once.
  task automatic doReset();
    reset = 1'b0;
    #1;
    checkResetZero("reset_zero");
    sbq.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    #1;
    reset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  // Let the pipeline empty, then require that every expected result appeared.
  task automatic drain();
    repeat (6) @(posedge Clk);
    #1;
    nTests++;
    if (sbq.size() != 0) begin
      nFail++;
      $display("[TB] FAIL drain %0d results missing, required 0 (first ch=%0d energy=%0d)",
               sbq.size(), sbq[0].ch, sbq[0].e);
      sbq.delete();
    end
  endtask

  task automatic runTable();
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].inst, tbl[i].ch, tbl[i].data, tbl[i].ev, tbl[i].ee, tbl[i].es, tbl[i].esp);
    end
    tbl.delete();
    drain();
  endtask

  initial begin
    #2;
    @(posedge Clk);
    #1;

    // Basic single channel: 5*5 - 2*3.
    doReset();
    addVec(0, 0, 3); addVec(0, 0, 5); addVec(0, 0, 2, 1, 19);
    runTable();

    // Interleaved channels stay independent.
    doReset();
    addVec(0, 0, 1);  addVec(0, 1, 10);
    addVec(0, 0, 2);  addVec(0, 1, 20);
    addVec(0, 0, 3, 1, 1); addVec(0, 1, 30, 1, 100);
    runTable();

    // K=2 warm-up of four samples, with out-of-range channel 3 dropped.
    doReset();
    addVec(1, 2, 1); addVec(1, 3, 9999); addVec(1, 2, 2); addVec(1, 3, -500);
    addVec(1, 2, 3); addVec(1, 2, 4); addVec(1, 3, 1234); addVec(1, 2, 5, 1, 4);
    runTable();

    // M=24 saturation in both directions, then an in-range result.
    doReset();
    addVec(2, 0, -32768); addVec(2, 0, -32768);
    addVec(2, 0, 32767, 1, 8388607, 1);
    addVec(2, 0, 0, 1, 8388607, 1);
    addVec(2, 0, 32767, 1, -8388608, 1);
    addVec(2, 0, 100, 1, 8388607, 1);
    addVec(2, 1, 100); addVec(2, 1, 200); addVec(2, 1, 300, 1, 10000, 0);
    runTable();

    // Refractory hold-off of two outputs; every energy is 100.
    thr32 = 50;
    rlen  = 2;
    doReset();
    addVec(0, 0, 0); addVec(0, 0, 10);
    addVec(0, 0, 0, 1, 100, 0, 1);  addVec(0, 0, -10, 1, 100, 0, 0);
    addVec(0, 0, 0, 1, 100, 0, 0);  addVec(0, 0, 10, 1, 100, 0, 1);
    addVec(0, 0, 0, 1, 100, 0, 0);
    runTable();

    // Hold-off disabled: every output spikes.
    rlen = 0;
    doReset();
    addVec(0, 0, 0); addVec(0, 0, 10);
    addVec(0, 0, 0, 1, 100, 0, 1);  addVec(0, 0, -10, 1, 100, 0, 1);
    addVec(0, 0, 0, 1, 100, 0, 1);  addVec(0, 0, 10, 1, 100, 0, 1);
    addVec(0, 0, 0, 1, 100, 0, 1);
    runTable();

    // Threshold is strict: equal does not fire, one below does.
    thr32 = 100;
    doReset();
    addVec(0, 0, 0); addVec(0, 0, 10); addVec(0, 0, 0, 1, 100, 0, 0);
    runTable();
    thr32 = 99;
    addVec(0, 0, -10, 1, 100, 0, 1);
    runTable();

    // Hold-off is tracked separately per channel.
    thr32 = 50;
    rlen  = 3;
    doReset();
    addVec(0, 0, 0);  addVec(0, 1, 0);
    addVec(0, 0, 10); addVec(0, 1, 10);
    addVec(0, 0, 0, 1, 100, 0, 1); addVec(0, 1, 0, 1, 100, 0, 1);
    addVec(0, 0, -10, 1, 100, 0, 0);
    runTable();

    // Reset in the middle of a ch1 stream restarts warm-up.
    thr32 = 32'sh7FFFFFFF;
    rlen  = 0;
    doReset();
    applyStimulus(0, 1, 3, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 0, 0);
    applyStimulus(0, 1, 2, 1, 19, 0, 0);
    applyStimulus(0, 1, 4, 1, -16, 0, 0);
    applyStimulus(0, 1, 6, 1, 4, 0, 0);
    @(negedge Clk);
    #1;
    reset = 1'b0;
    #1;
    checkResetZero("midstream_reset_zero");
    sbq.delete();
    #2;
    reset = 1'b1;
    @(posedge Clk);
    #1;
    addVec(0, 1, 7); addVec(0, 1, 1); addVec(0, 1, 2, 1, -13);
    runTable();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
